// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared segment types and the active-low hex glyph table
package segment_pkg;

  // Segment word: bit 1 = a ... bit 7 = g, active-low
  typedef logic [7:1] seg_word_t;

  localparam seg_word_t SEG_BLANK = 7'h7F;

  // Active-low glyphs for 0..F (A, b, C, d, E, F for the letters)
  localparam seg_word_t SEG_HEX_GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational nibble to active-low segment decoder
module seg_hex_decoder
  import segment_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_word_t  o_segments
);

  assign o_segments = SEG_HEX_GLYPHS[i_nibble];

endmodule

// File: rtl/segment_mux_driver.sv
// rtl/segment_mux_driver.sv - multiplexed seven-segment driver; SEGMENT_BLINK_EN adds per-digit blinking
module segment_mux_driver
  import segment_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk100Mhz,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   display_value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic [DIGITS-1:0]     blink_mask,
  output seg_word_t             cathodes,
  output logic                  dp,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_start
);

  localparam int TICK_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLICE  = REFRESH_DIV >> BRIGHT_W;

  logic [TICK_W-1:0]   r_tick_cnt;
  logic [IDX_W-1:0]    r_digit_idx;

  logic [4*DIGITS-1:0] r_value_sh;
  logic [DIGITS-1:0]   r_dp_sh;
  logic                r_blank_lz_sh;
  logic [BRIGHT_W-1:0] r_bright_sh;

  logic [DIGITS-1:0]   r_anodes;
  seg_word_t           r_cathodes;
  logic                r_dp;
  logic                r_frame_start;

  logic                w_boundary;
  logic [4*DIGITS-1:0] w_cur_value;
  logic [DIGITS-1:0]   w_cur_dp;
  logic                w_cur_blank_lz;
  logic [BRIGHT_W-1:0] w_cur_bright;
  logic [DIGITS-1:0]   w_lz_blank;
  logic                w_blink_blank;
  logic                w_blank;
  logic [31:0]         w_on_limit;
  logic                w_lit;
  logic [3:0]          w_nibble;
  seg_word_t           w_glyph;
  logic [DIGITS-1:0]   w_onehot;

  assign w_boundary = (r_digit_idx == '0) && (r_tick_cnt == '0);

  // The boundary cycle already displays the freshly latched inputs, so the
  // whole frame (including its first cycle) is drawn from one snapshot.
  assign w_cur_value    = w_boundary ? display_value : r_value_sh;
  assign w_cur_dp       = w_boundary ? dp_mask       : r_dp_sh;
  assign w_cur_blank_lz = w_boundary ? blank_lz      : r_blank_lz_sh;
  assign w_cur_bright   = w_boundary ? brightness    : r_bright_sh;

  // Slot tick counter and digit index
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (r_tick_cnt == TICK_W'(REFRESH_DIV - 1)) begin
      r_tick_cnt  <= '0;
      r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
    end else begin
      r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Shadow registers captured once per frame
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_value_sh    <= '0;
      r_dp_sh       <= '0;
      r_blank_lz_sh <= 1'b0;
      r_bright_sh   <= '0;
    end else if (w_boundary) begin
      r_value_sh    <= display_value;
      r_dp_sh       <= dp_mask;
      r_blank_lz_sh <= blank_lz;
      r_bright_sh   <= brightness;
    end
  end

  // Leading-zero blanking: walk down from the top digit while nibbles are zero and no dp is set
  always_comb begin : lz_scan
    logic run_zero;
    w_lz_blank = '0;
    run_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero      = run_zero && (w_cur_value[4*i +: 4] == 4'h0) && !w_cur_dp[i];
      w_lz_blank[i] = w_cur_blank_lz && run_zero;
    end
  end

`ifdef SEGMENT_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink_on;
  logic [DIGITS-1:0] r_bmask_sh;
  logic              w_blink_toggle;
  logic              w_cur_phase;
  logic [DIGITS-1:0] w_cur_bmask;

  // The counter holds the number of frames already spent in the current phase
  assign w_blink_toggle = w_boundary && (r_frame_cnt == FC_W'(BLINK_FRAMES));
  assign w_cur_phase    = w_blink_toggle ? ~r_blink_on : r_blink_on;
  assign w_cur_bmask    = w_boundary ? blink_mask : r_bmask_sh;
  assign w_blink_blank  = ~w_cur_phase & w_cur_bmask[r_digit_idx];

  // Blink phase tracking and blink mask latch
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
      r_bmask_sh  <= '0;
    end else if (w_boundary) begin
      r_bmask_sh <= blink_mask;
      if (w_blink_toggle) begin
        r_blink_on  <= ~r_blink_on;
        r_frame_cnt <= FC_W'(1);
      end else begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end
  end
`else
  logic w_unused_blink;

  assign w_unused_blink = ^blink_mask;
  assign w_blink_blank  = 1'b0;
`endif

  assign w_blank    = w_lz_blank[r_digit_idx] | w_blink_blank;
  assign w_on_limit = (32'(w_cur_bright) + 32'd1) * 32'(SLICE);
  assign w_lit      = (32'(r_tick_cnt) < w_on_limit);
  assign w_nibble   = w_cur_value[4*r_digit_idx +: 4];
  assign w_onehot   = DIGITS'(1) << r_digit_idx;

  seg_hex_decoder u_dec (
    .i_nibble   (w_nibble),
    .o_segments (w_glyph)
  );

  // Registered pin drivers; one-hot anode only inside the brightness window
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_anodes      <= '1;
      r_cathodes    <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_boundary;
      if (w_blank) begin
        r_anodes   <= '1;
        r_cathodes <= SEG_BLANK;
        r_dp       <= 1'b1;
      end else begin
        r_anodes   <= w_lit ? ~w_onehot : '1;
        r_cathodes <= w_glyph;
        r_dp       <= ~w_cur_dp[r_digit_idx];
      end
    end
  end

  assign anodes      = r_anodes;
  assign cathodes    = r_cathodes;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_segment_mux_driver.sv
// tb/tb_segment_mux_driver.sv - scoreboard bench for segment_mux_driver
module tb_segment_mux_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 16;
  localparam int BW     = 2;
  localparam int BF     = 2;
  localparam int PERIOD = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] display_value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  blink_mask = '0;
  logic [7:1]  cathodes;
  logic        dp;
  logic [3:0]  anodes;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  segment_mux_driver #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (DIV),
    .BRIGHT_W     (BW),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk100Mhz     (clk),
    .rst_n         (rst_n),
    .display_value (display_value),
    .dp_mask       (dp_mask),
    .blank_lz      (blank_lz),
    .brightness    (brightness),
    .blink_mask    (blink_mask),
    .cathodes      (cathodes),
    .dp            (dp),
    .anodes        (anodes),
    .frame_start   (frame_start)
  );

  // Standard active-high gfedcba glyphs
  logic [6:0] glyph_hi [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [12:0] RESET_WORD = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic [12:0] exp_q [$];
  int          k;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [1:0]  m_br;
  logic [3:0]  m_bm;
  logic [12:0] got;

  function automatic logic [12:0] expect_word(int kk);
    int pos  = kk % PERIOD;
    int d    = pos / DIV;
    int tick = pos % DIV;
    int f    = kk / PERIOD;
    bit blank = 1'b0;
    bit lit;
    logic [3:0] an;
    logic [6:0] ca;
    logic       dpb;
    if (m_blz && d != 0) begin
      blank = 1'b1;
      for (int j = d; j < DIGITS; j++)
        if (m_val[4*j +: 4] != 4'h0 || m_dp[j]) blank = 1'b0;
    end
`ifdef SEGMENT_BLINK_EN
    if (((f / BF) % 2) == 1 && m_bm[d]) blank = 1'b1;
`else
    if (f < 0) blank = 1'b1;
`endif
    lit = tick < (int'(m_br) + 1) * (DIV / (1 << BW));
    if (blank) begin
      an  = 4'hF;
      ca  = 7'h7F;
      dpb = 1'b1;
    end else begin
      an  = lit ? ~(4'b0001 << d) : 4'hF;
      ca  = ~glyph_hi[m_val[4*d +: 4]];
      dpb = ~m_dp[d];
    end
    return {an, ca, dpb, (pos == 0)};
  endfunction

  // Reference model: one expected output word per clock after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
    end else begin
      if (k % PERIOD == 0) begin
        m_val = display_value;
        m_dp  = dp_mask;
        m_blz = blank_lz;
        m_br  = brightness;
        m_bm  = blink_mask;
      end
      exp_q.push_back(expect_word(k));
      k++;
    end
  end

  task automatic check(string name, logic [12:0] act, logic [12:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got an=%b ca=%h dp=%b fs=%b need an=%b ca=%h dp=%b fs=%b",
               name, $time, act[12:9], act[8:2], act[1], act[0],
               req[12:9], req[8:2], req[1], req[0]);
    end
  endtask

  // Monitor: compares DUT pins against the scoreboard away from the clock edge
  always @(negedge clk) begin
    got = {anodes, cathodes, dp, frame_start};
    if (!rst_n) begin
      exp_q.delete();
      check("reset_hold", got, RESET_WORD);
    end else if (exp_q.size() > 0) begin
      check("scan", got, exp_q.pop_front());
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    blink_mask    = 4'b0001;
    display_value = 16'h1234;
    dp_mask       = 4'b0100;
    brightness    = 2'd3;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // basic scan, then leading-zero blanking with and without a high dp
    wait_cycles(2 * PERIOD);
    blank_lz = 1'b1; display_value = 16'h0050; dp_mask = 4'b0000;
    wait_cycles(2 * PERIOD);
    dp_mask = 4'b1000;
    wait_cycles(2 * PERIOD);

    // brightness levels
    blank_lz = 1'b0; dp_mask = 4'b0000; display_value = 16'hABCD;
    brightness = 2'd0;
    wait_cycles(2 * PERIOD);
    brightness = 2'd2;
    wait_cycles(2 * PERIOD);

    // mid-frame change must wait for the next frame
    brightness = 2'd3; display_value = 16'h1234;
    wait_cycles(PERIOD + 20);
    display_value = 16'h5678;
    wait_cycles(2 * PERIOD);

    // randomized inputs changing at arbitrary points in the frame
    for (int i = 0; i < 30; i++) begin
      display_value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) display_value[15:8] = 8'h00;
      dp_mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      blank_lz   = 1'($urandom);
      brightness = 2'($urandom);
      blink_mask = 4'($urandom);
      wait_cycles($urandom_range(1, 120));
    end

    // asynchronous reset in the middle of a slot
    blink_mask = 4'b0001;
    wait_cycles(37);
    rst_n = 1'b0;
    #1 check("async_reset", {anodes, cathodes, dp, frame_start}, RESET_WORD);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cycles(6 * PERIOD);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segment_mux_driver.md
# segment_mux_driver

Parametrised multiplexed seven-segment display driver and the successor to the fixed 4-digit segment driver. It scans `DIGITS` common-anode digits from one packed hex value. Over the original it adds:
- per-digit decimal points
- leading-zero blanking
- PWM brightness control
- tear-free frame latching of the inputs
- optional per-digit blinking

It sits between the step/distance formatting logic and the board's anode/cathode pins.

## Interface
- `DIGITS`, 4: number of digits scanned, 2..8
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be a multiple of 2^`BRIGHT_W`
- `BRIGHT_W`, 3: brightness control width
- `BLINK_FRAMES`, 64: frames per blink half-period
- `clk100Mhz` in 1: system clock, 100 MHz
- `rst_n` in 1: asynchronous, active-low reset
- `display_value` in 4*`DIGITS`: hex nibbles; nibble 0 is the rightmost digit
- `dp_mask` in `DIGITS`: decimal point enable per digit
- `blank_lz` in 1: enables leading-zero blanking
- `brightness` in `BRIGHT_W`: on-time level; 0 is dimmest, all-ones is full
- `blink_mask` in `DIGITS`: digits that blink; used only with `SEGMENT_BLINK_EN`
- `cathodes` out [7:1]: segments a..g on bits 1..7, active-low
- `dp` out 1: decimal point cathode, active-low
- `anodes` out `DIGITS`: digit enables, active-low; bit 0 is the rightmost digit
- `frame_start` out 1: one-cycle pulse when a new frame latches its inputs

## Operation
- **Slot counter.** `tick_cnt` runs 0..`REFRESH_DIV`-1 and defines one digit slot.
- **Digit index.** `digit_idx` increments when `tick_cnt` wraps, and itself wraps from `DIGITS`-1 to 0.
- **Frame boundary and latching.** A frame boundary is `digit_idx`==0 and `tick_cnt`==0. At each boundary the block:
  - latches `display_value`, `dp_mask`, `blank_lz` and `brightness` into shadow registers;
  - pulses `frame_start`.
  
  Input changes mid-frame have no visible effect until the next frame.
- **Decode.** Nibbles 0..F use the standard hex glyphs (A, b, C, d, E, F).
- **Leading-zero blanking** (when latched `blank_lz`=1):
  - A digit is blank if its nibble and every more-significant nibble are 0, and no `dp_mask` bit at or above it is set.
  - Digit 0 is never blanked.
  - A blank digit drives its anode high (off), `cathodes`=7'h7F and `dp`=1.
- **Brightness.** The active digit's anode is low only while `tick_cnt` < (`brightness`+1)·(`REFRESH_DIV`>>`BRIGHT_W`). Outside that window all anodes are high. At full scale the digit is on for the entire slot.
- **Single-active rule.** At most one anode is low in any cycle.
- **Reset mid-operation.** Everything returns to its reset values immediately, and the next frame starts at digit 0.

## Timing
- **Reset values:**
  - `anodes` all 1, `cathodes` 7'h7F, `dp` 1, `frame_start` 0
  - counters 0, shadow registers 0
  - blink phase: on
- All outputs are registered. Anodes, cathodes and `dp` reflect `digit_idx` and `tick_cnt` with 1 cycle of latency.
- `frame_start` is asserted in the cycle after the boundary count is reached.
- The first frame latch happens on the first boundary after reset release.
- Frame period is `DIGITS`·`REFRESH_DIV` cycles, i.e. 4 ms at the default parameters.

## Configuration
- **`SEGMENT_BLINK_EN` defined:**
  - A frame counter toggles the blink phase every `BLINK_FRAMES` frames.
  - `blink_mask` is latched at each frame boundary.
  - During the off phase, masked digits are treated as blank.
  - The phase starts "on" after reset.
- **`SEGMENT_BLINK_EN` undefined:**
  - No blink logic is built.
  - The `blink_mask` port still exists and is ignored.

## Structure
- **Package `segment_pkg`:**
  - `SEG_BLANK` (7'h7F)
  - the 16-entry active-low hex glyph constant array
  - a `seg_word_t` typedef for [7:1]
- **Sub-module `seg_hex_decoder`:** combinational nibble-to-segment decoder, instantiated once on the selected nibble.

## Test plan
All scenarios use `DIGITS`=4, `REFRESH_DIV`=16, `BRIGHT_W`=2.
1. **Reset hold.** Hold `rst_n`=0 -> `anodes`=4'hF, `cathodes`=7'h7F, `dp`=1, `frame_start`=0.
2. **Basic scan.** `display_value`=16'h1234, `dp_mask`=4'b0100, `brightness`=3 -> anodes cycle 1110, 1101, 1011, 0111 with 16 cycles each. Digit 0 shows the glyph for 4, digit 2 shows 2 with `dp`=0, and `frame_start` pulses every 64 cycles.
3. **Leading-zero blanking.** `blank_lz`=1, value 16'h0050 -> digits 3 and 2 have anodes high. Digit 1 shows 5 and digit 0 shows 0. Setting `dp_mask`=4'b1000 unblanks digits 3 and 2, which show 0.
4. **Brightness.** `brightness`=0 -> the active anode is low for 4 of 16 cycles per slot. `brightness`=2 -> low for 12 of 16 cycles.
5. **Tear-free latching.** Change the value from 16'h1234 to 16'h5678 mid-frame -> the current frame still shows 1234, and the next `frame_start` frame shows 5678.
6. **Blink and mid-operation reset.** With `SEGMENT_BLINK_EN`, `BLINK_FRAMES`=2 and `blink_mask`=4'b0001 -> digit 0 is dark during frames 2-3 and lit during frames 0-1 and 4-5. Then pulse `rst_n` low mid-slot -> outputs return to reset values within the same cycle, and the scan restarts at digit 0.
